// File: rtl/systolic_skew_feeder_if.sv
// Row handshake between the upstream row source and the skew feeder.
// The master drives a row with its last-row marker and the slave
// answers with in_ready.
interface systolic_skew_feeder_if #(
    parameter int N = 4,
    parameter int W = 32
);
    logic           in_valid;
    logic           in_ready;
    logic [N*W-1:0] in_data;
    logic           in_last;

    // Upstream row source.
    modport master (
        output in_valid,
        output in_data,
        output in_last,
        input  in_ready
    );

    // Skew feeder.
    modport slave (
        input  in_valid,
        input  in_data,
        input  in_last,
        output in_ready
    );
endinterface

// File: rtl/systolic_skew_feeder.sv
// Systolic array input stage: accepts one row of N words per handshake
// and re-times it into N diagonally skewed lanes (lane j delayed by j
// extra cycles). The first row of each matrix is tagged with s, input is
// blocked while the skew pipeline drains after the last row, and done
// pulses when the final word leaves lane N-1.
module systolic_skew_feeder #(
    parameter int N = 4,
    parameter int W = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    systolic_skew_feeder_if.slave up,
    output logic [N*W-1:0]       x_out,
    output logic [N-1:0]         s_out,
    output logic [N-1:0]         v_out,
    output logic                 busy,
    output logic                 done
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DRAIN  = 2'd2
    } state_t;

    // The drain counter only has to hold N-2; keep at least one bit so the
    // N=1 and N=2 builds still elaborate.
    localparam int          CW         = (N > 2) ? $clog2(N - 1) : 1;
    localparam logic [CW-1:0] DRAIN_LOAD = CW'((N >= 2) ? N - 2 : 0);

    state_t        state_q;
    logic [CW-1:0] cnt_q;
    logic          ready_q;
    logic          busy_q;
    logic          done_q;

    logic accept;
    logic first_row;

    // in_ready is a pure function of state, so it is kept as a register and
    // never looks at in_valid.
    assign accept       = up.in_valid & ready_q;
    assign first_row    = (state_q == IDLE);
    assign up.in_ready  = ready_q;
    assign busy         = busy_q;
    assign done         = done_q;

    // Control FSM: matrix framing, drain blocking and done pulse.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values; blocking here would let later statements see
            // already-updated state and break the one-edge pipeline timing.
            done_q <= 1'b0;
            case (state_q)
                IDLE, STREAM: begin
                    if (accept) begin
                        if (up.in_last) begin
                            if (N == 1) begin
                                // Single lane: the last word is already out
                                // of the pipeline on the next cycle.
                                state_q <= IDLE;
                                ready_q <= 1'b1;
                                busy_q  <= 1'b0;
                                done_q  <= 1'b1;
                            end else begin
                                state_q <= DRAIN;
                                cnt_q   <= DRAIN_LOAD;
                                ready_q <= 1'b0;
                                busy_q  <= 1'b1;
                            end
                        end else begin
                            state_q <= STREAM;
                            ready_q <= 1'b1;
                            busy_q  <= 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    if (cnt_q == '0) begin
                        state_q <= IDLE;
                        ready_q <= 1'b1;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    cnt_q   <= '0;
                    ready_q <= 1'b1;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    // One shift chain per lane; lane j has j+1 stages and never stalls.
    for (genvar j = 0; j < N; j++) begin : g_lane
        logic [W-1:0] d_q [0:j];
        logic         s_q [0:j];
        logic         v_q [0:j];

        // Shift the lane every edge; stage 0 takes the new word or a bubble.
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                // NOTE: these are short pipeline registers, not a RAM, so
                // they are all reset; a reset must drop in-flight rows and
                // leave the array inputs at zero.
                for (int i = 0; i <= j; i++) begin
                    d_q[i] <= '0;
                    s_q[i] <= 1'b0;
                    v_q[i] <= 1'b0;
                end
            end else begin
                d_q[0] <= accept ? up.in_data[j*W +: W] : '0;
                s_q[0] <= accept & first_row;
                v_q[0] <= accept;
                for (int i = 1; i <= j; i++) begin
                    d_q[i] <= d_q[i-1];
                    s_q[i] <= s_q[i-1];
                    v_q[i] <= v_q[i-1];
                end
            end
        end

        assign x_out[j*W +: W] = d_q[j];
        assign s_out[j]        = s_q[j];
        assign v_out[j]        = v_q[j];
    end

endmodule

// File: tb/tb_systolic_skew_feeder.sv
// Scoreboard bench for systolic_skew_feeder: an N=4 and an N=1 instance.
// Stimulus pushes the expected per-lane words (with the cycle they must
// appear) and done cycles; a negedge monitor pops and compares.
module tb_systolic_skew_feeder;

    localparam int W = 32;

    typedef struct {
        logic [31:0] data;
        logic        s;
        int          cyc;
    } exp_t;

    logic clk;
    logic rst;
    int   cyc = 0;

    int n_pass  = 0;
    int n_total = 0;

    exp_t lq4 [4][$];
    exp_t lq1 [$];
    int   dq4 [$];
    int   dq1 [$];

    systolic_skew_feeder_if #(.N(4), .W(W)) bus4 ();
    systolic_skew_feeder_if #(.N(1), .W(W)) bus1 ();

    logic [4*W-1:0] x4;
    logic [3:0]     s4, v4;
    logic           busy4, done4;
    logic [W-1:0]   x1;
    logic [0:0]     s1, v1;
    logic           busy1, done1;

    systolic_skew_feeder #(.N(4), .W(W)) u_dut4 (
        .clk   (clk),
        .rst   (rst),
        .up    (bus4),
        .x_out (x4),
        .s_out (s4),
        .v_out (v4),
        .busy  (busy4),
        .done  (done4)
    );

    systolic_skew_feeder #(.N(1), .W(W)) u_dut1 (
        .clk   (clk),
        .rst   (rst),
        .up    (bus1),
        .x_out (x1),
        .s_out (s1),
        .v_out (v1),
        .busy  (busy1),
        .done  (done1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %h, required %h (cycle %0d)", name, act, req, cyc);
    endtask

    // Monitor: compare whatever the DUTs present against the scoreboard.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (rst) begin
            for (int j = 0; j < 4; j++) begin
                if (v4[j]) begin
                    if (lq4[j].size() == 0) begin
                        check($sformatf("lane%0d_unexpected", j), 64'(v4[j]), 64'd0);
                    end else begin
                        e = lq4[j].pop_front();
                        check($sformatf("lane%0d_word", j),
                              {cyc[30:0], s4[j], x4[j*32 +: 32]},
                              {e.cyc[30:0], e.s, e.data});
                    end
                end else begin
                    check($sformatf("lane%0d_bubble", j), {31'd0, s4[j], x4[j*32 +: 32]}, 64'd0);
                end
            end
            if (done4) begin
                if (dq4.size() == 0) check("done4_unexpected", 64'(done4), 64'd0);
                else check("done4_cycle", 64'(cyc), 64'(dq4.pop_front()));
            end
            if (v1[0]) begin
                if (lq1.size() == 0) begin
                    check("n1_unexpected", 64'(v1[0]), 64'd0);
                end else begin
                    e = lq1.pop_front();
                    check("n1_word", {cyc[30:0], s1[0], x1}, {e.cyc[30:0], e.s, e.data});
                end
            end else begin
                check("n1_bubble", {31'd0, s1[0], x1}, 64'd0);
            end
            if (done1) begin
                if (dq1.size() == 0) check("done1_unexpected", 64'(done1), 64'd0);
                else check("done1_cycle", 64'(cyc), 64'(dq1.pop_front()));
            end
        end
    end

    task automatic push4(input int k, input logic [4*W-1:0] row, input logic first);
        exp_t e;
        for (int j = 0; j < 4; j++) begin
            e.data = row[j*32 +: 32];
            e.s    = first;
            e.cyc  = k + j;
            lq4[j].push_back(e);
        end
    endtask

    // Present a row, confirm it is accepted at the next edge, record expectations.
    task automatic send4(input logic [4*W-1:0] row, input logic last, input logic first,
                         input string tag);
        int k;
        bus4.in_valid = 1'b1;
        bus4.in_data  = row;
        bus4.in_last  = last;
        @(negedge clk);
        check({tag, "_ready"}, 64'(bus4.in_ready), 64'd1);
        k = cyc + 1;
        push4(k, row, first);
        if (last) dq4.push_back(k + 3);
        @(posedge clk);
        #1;
        bus4.in_valid = 1'b0;
        bus4.in_last  = 1'b0;
    endtask

    task automatic wait_drain4();
        for (int i = 0; i < 40 && dq4.size() != 0; i++) @(negedge clk);
        check("drain_timeout", 64'(dq4.size()), 64'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got no finish, required finish before 200000");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int k;
        exp_t e;
        logic [31:0] n1_rows [2];

        // Reset with in_valid held high.
        rst           = 1'b0;
        bus4.in_valid = 1'b1;
        bus4.in_data  = {32'h41200000, 32'hC0200000, 32'h40000000, 32'h40900000};
        bus4.in_last  = 1'b0;
        bus1.in_valid = 1'b1;
        bus1.in_data  = 32'h12345678;
        bus1.in_last  = 1'b0;
        #12;
        check("rst_ready4", 64'(bus4.in_ready), 64'd1);
        check("rst_busy_done4", {62'd0, busy4, done4}, 64'd0);
        check("rst_x4_lo", x4[63:0], 64'd0);
        check("rst_x4_hi", x4[127:64], 64'd0);
        check("rst_vs4", {56'd0, v4, s4}, 64'd0);
        check("rst_n1", {busy1, done1, v1, s1, x1}, 64'd0);
        check("rst_ready1", 64'(bus1.in_ready), 64'd1);
        #4;
        rst           = 1'b1;
        bus4.in_valid = 1'b0;
        bus1.in_valid = 1'b0;
        @(posedge clk);
        #1;

        // Three-row matrix back to back.
        send4({32'h41200000, 32'hC0200000, 32'h40000000, 32'h40900000}, 1'b0, 1'b1, "a0");
        send4({32'h7F800000, 32'h00000000, 32'hBF800000, 32'h3F800000}, 1'b0, 1'b0, "a1");
        send4({32'h3E800000, 32'h7FC00000, 32'h80000000, 32'h42C80000}, 1'b1, 1'b0, "a2");
        repeat (3) begin
            @(negedge clk);
            check("a_drain_ready", 64'(bus4.in_ready), 64'd0);
            check("a_drain_busy", 64'(busy4), 64'd1);
        end
        @(negedge clk);
        check("a_ready_back", 64'(bus4.in_ready), 64'd1);
        wait_drain4();

        // Two bubble cycles between rows 1 and 2.
        send4({32'h00000004, 32'h00000003, 32'h00000002, 32'h00000001}, 1'b0, 1'b1, "b0");
        send4({32'hA0A0A0A0, 32'h0B0B0B0B, 32'hC0C0C0C0, 32'h0D0D0D0D}, 1'b0, 1'b0, "b1");
        repeat (2) begin
            @(negedge clk);
            check("b_bubble_ready", 64'(bus4.in_ready), 64'd1);
            @(posedge clk);
        end
        #1;
        send4({32'hFFFFFFFF, 32'h80000001, 32'h00800000, 32'hDEADBEEF}, 1'b1, 1'b0, "b2");
        wait_drain4();

        // Row offered during drain must wait for IDLE and start a new matrix.
        send4({32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444}, 1'b1, 1'b1, "c0");
        bus4.in_valid = 1'b1;
        bus4.in_data  = {32'h55555555, 32'h66666666, 32'h77777777, 32'h88888888};
        bus4.in_last  = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("bp_ready_low", 64'(bus4.in_ready), 64'd0);
        end
        @(negedge clk);
        check("bp_ready_high", 64'(bus4.in_ready), 64'd1);
        k = cyc + 1;
        push4(k, {32'h55555555, 32'h66666666, 32'h77777777, 32'h88888888}, 1'b1);
        dq4.push_back(k + 3);
        @(posedge clk);
        #1;
        bus4.in_valid = 1'b0;
        bus4.in_last  = 1'b0;
        wait_drain4();

        // Reset one cycle into DRAIN: everything in flight is dropped.
        send4({32'h01010101, 32'h02020202, 32'h03030303, 32'h04040404}, 1'b0, 1'b1, "e0");
        send4({32'h05050505, 32'h06060606, 32'h07070707, 32'h08080808}, 1'b1, 1'b0, "e1");
        @(posedge clk);
        #2;
        rst = 1'b0;
        for (int j = 0; j < 4; j++) lq4[j].delete();
        dq4.delete();
        #1;
        check("mid_rst_x_lo", x4[63:0], 64'd0);
        check("mid_rst_x_hi", x4[127:64], 64'd0);
        check("mid_rst_vs", {56'd0, v4, s4}, 64'd0);
        check("mid_rst_ctrl", {61'd0, bus4.in_ready, busy4, done4}, 64'd4);
        repeat (2) @(posedge clk);
        #3;
        rst = 1'b1;
        @(negedge clk);
        check("post_rst_ctrl", {62'd0, bus4.in_ready, busy4}, 64'd2);
        repeat (6) @(negedge clk);
        @(posedge clk);
        #1;
        send4({32'hCAFEF00D, 32'h0000FFFF, 32'h3F000000, 32'hBEEFCAFE}, 1'b1, 1'b1, "f0");
        wait_drain4();

        // N=1: two single-row matrices back to back, ready never drops.
        n1_rows[0] = 32'h43004CCD;
        n1_rows[1] = 32'h3F800000;
        for (int r = 0; r < 2; r++) begin
            bus1.in_valid = 1'b1;
            bus1.in_data  = n1_rows[r];
            bus1.in_last  = 1'b1;
            @(negedge clk);
            check("n1_ready", 64'(bus1.in_ready), 64'd1);
            k      = cyc + 1;
            e.data = n1_rows[r];
            e.s    = 1'b1;
            e.cyc  = k;
            lq1.push_back(e);
            dq1.push_back(k);
            @(posedge clk);
            #1;
        end
        bus1.in_valid = 1'b0;
        bus1.in_last  = 1'b0;
        @(negedge clk);
        check("n1_ready_after", 64'(bus1.in_ready), 64'd1);
        repeat (3) @(negedge clk);

        for (int j = 0; j < 4; j++)
            check($sformatf("lane%0d_leftover", j), 64'(lq4[j].size()), 64'd0);
        check("done4_leftover", 64'(dq4.size()), 64'd0);
        check("n1_leftover", 64'(lq1.size()), 64'd0);
        check("done1_leftover", 64'(dq1.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
